cacheline_arbiter: RTL and testbench
====================================

# cacheline_arbiter

Two-requester arbiter sharing the single physical-memory port between the instruction cache (IF stage) and the data cache (MEM stage) of the pipelined RV32I core. It grants one full-cacheline transaction at a time and holds the grant until physical memory responds. It steers `pmem_rdata` and `pmem_resp` back to the granted cache only. A mandatory release cycle after every response guarantees a requester's stale request is never re-granted.

## Interface
- `LINE_WIDTH`, 256: cacheline width in bits.
- `ADDR_WIDTH`, 32: byte address width.

- `clk` input 1: the single clock; all state changes on rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `i_read` input 1: I-cache line-fill request; level, held until `i_resp`.
- `i_address` input ADDR_WIDTH: I-cache line address.
- `i_rdata` output LINE_WIDTH: fill data to I-cache.
- `i_resp` output 1: one-cycle completion pulse to I-cache.
- `d_read` input 1: D-cache fill request; level.
- `d_write` input 1: D-cache writeback request; level.
- `d_address` input ADDR_WIDTH: D-cache line address.
- `d_wdata` input LINE_WIDTH: writeback line.
- `d_rdata` output LINE_WIDTH: fill data to D-cache.
- `d_resp` output 1: one-cycle completion pulse to D-cache.
- `pmem_read` output 1: physical memory read strobe; registered.
- `pmem_write` output 1: physical memory write strobe; registered.
- `pmem_address` output ADDR_WIDTH: registered transaction address.
- `pmem_wdata` output LINE_WIDTH: registered write line.
- `pmem_rdata` input LINE_WIDTH: read line from memory.
- `pmem_resp` input 1: memory completion pulse.

## Operation
- States: IDLE, SERVE_I, SERVE_D, RELEASE.
- IDLE, no request: stay.
- IDLE, a request is present: arbitrate (see Configuration).
  - Register `pmem_address`. Register `pmem_wdata` for a D write.
  - Set `pmem_read`/`pmem_write` and enter SERVE_I or SERVE_D.
- `d_read` and `d_write` both high: treat as write. A simulation assertion flags it.
- SERVE_x: hold all `pmem_*` outputs constant. Requester inputs are not re-sampled.
- SERVE_x, `pmem_resp`=1:
  - Drive `x_resp`=1 in the same cycle, with `x_rdata`=`pmem_rdata` (combinational passthrough).
  - Clear `pmem_read`/`pmem_write` at the edge and go to RELEASE.
- RELEASE: lasts exactly one cycle. Requests are ignored; go to IDLE.
- Non-granted `x_resp` is always 0. Both `x_rdata` outputs carry `pmem_rdata` continuously; only `x_resp` qualifies them.
- `pmem_resp` outside SERVE_x is ignored.
- Requester drops its request mid-transaction: the transaction still completes and `x_resp` still pulses.
- Reset values: state IDLE; `pmem_read`, `pmem_write`, `i_resp`, `d_resp` = 0; `pmem_address`, `pmem_wdata` = 0; last-grant flag = I.
- Reset mid-transaction:
  - Strobes drop immediately (asynchronous).
  - The in-flight `pmem_resp` is discarded and no `x_resp` pulses.

## Timing
- Request seen in IDLE at cycle 0 -> `pmem_read`/`pmem_write` high from cycle 1.
- `pmem_resp` at cycle k -> `x_resp` at cycle k, strobes low at k+1 (RELEASE), IDLE at k+2.
- Next grant is sampled at k+2; its strobe rises at k+3.
- Minimum spacing between grants: 3 cycles plus memory latency.
- `x_resp` is a single-cycle pulse, never two consecutive cycles.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined:
  - On contention in IDLE, grant the requester not granted most recently (last-grant flag updated at every grant).
  - Single requester: always granted.
- Not defined:
  - Fixed priority, D-cache over I-cache.
  - Last-grant flag absent.
  - I-cache can starve under continuous D traffic.

## Test plan
- I fill alone:
  - Stimulus: `i_read`=1, `i_address`=0x0000_0060; memory responds 3 cycles after strobe with `pmem_rdata`=0xA5 repeated.
  - Required: `pmem_read` high cycles 1-4, `pmem_address`=0x60, `i_resp` pulse at cycle 4 with matching data, `d_resp`=0 throughout.
- D writeback:
  - Stimulus: `d_write`=1, `d_address`=0x8000_0040, `d_wdata`=0x1234…, memory latency 5.
  - Required: `pmem_write`=1 and `pmem_wdata` stable over all 5 cycles, one `d_resp` pulse.
- Simultaneous `i_read` and `d_read` from reset:
  - Required: D granted first.
  - Round-robin build: next D+I contention grants I. Fixed build: D again.
- Held stale request:
  - Stimulus: requester keeps `i_read`=1 one cycle past `i_resp`.
  - Required: no second `pmem_read` is issued during RELEASE.
- Reset mid-transaction:
  - Stimulus: assert `rst` two cycles into SERVE_D, then a late `pmem_resp` arrives.
  - Required: strobes drop asynchronously, `d_resp` stays 0, state IDLE.
- Spurious `pmem_resp` in IDLE:
  - Required: no `x_resp`, no state change.

Source files
------------

// File: rtl/cacheline_arbiter.sv
// rtl/cacheline_arbiter.sv - I/D cacheline arbiter for one physical-memory port (optional ARB_ROUND_ROBIN_EN)
module cacheline_arbiter #(
    parameter int LINE_WIDTH = 256,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_read,
    input  logic [ADDR_WIDTH-1:0] i_address,
    output logic [LINE_WIDTH-1:0] i_rdata,
    output logic                  i_resp,
    input  logic                  d_read,
    input  logic                  d_write,
    input  logic [ADDR_WIDTH-1:0] d_address,
    input  logic [LINE_WIDTH-1:0] d_wdata,
    output logic [LINE_WIDTH-1:0] d_rdata,
    output logic                  d_resp,
    output logic                  pmem_read,
    output logic                  pmem_write,
    output logic [ADDR_WIDTH-1:0] pmem_address,
    output logic [LINE_WIDTH-1:0] pmem_wdata,
    input  logic [LINE_WIDTH-1:0] pmem_rdata,
    input  logic                  pmem_resp
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SERVE_I = 2'd1,
        SERVE_D = 2'd2,
        RELEASE = 2'd3
    } state_t;

    state_t                  state, state_next;
    logic                    read_next, write_next;
    logic [ADDR_WIDTH-1:0]   address_next;
    logic [LINE_WIDTH-1:0]   wdata_next;
    logic                    i_req, d_req, grant_d;

`ifdef ARB_ROUND_ROBIN_EN
    // Set when the most recent grant went to the D-cache.
    logic                    last_d, last_d_next;
`endif

    // Both caches see the memory line at all times; only x_resp qualifies it.
    assign i_rdata = pmem_rdata;
    assign d_rdata = pmem_rdata;

    // Arbitration decision used only in IDLE.
    always_comb begin
        i_req = i_read;
        d_req = d_read | d_write;
`ifdef ARB_ROUND_ROBIN_EN
        grant_d = d_req && (!i_req || !last_d);
`else
        grant_d = d_req;
`endif
    end

    // Next-state, next-strobe and response logic.
    always_comb begin
        state_next   = state;
        read_next    = pmem_read;
        write_next   = pmem_write;
        address_next = pmem_address;
        wdata_next   = pmem_wdata;
        i_resp       = 1'b0;
        d_resp       = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d_next  = last_d;
`endif
        case (state)
            IDLE: begin
                if (grant_d) begin
                    state_next   = SERVE_D;
                    address_next = d_address;
                    // A simultaneous read and write is treated as the writeback.
                    if (d_write) begin
                        write_next = 1'b1;
                        wdata_next = d_wdata;
                    end else begin
                        read_next  = 1'b1;
                    end
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_next = 1'b1;
`endif
                end else if (i_req) begin
                    state_next   = SERVE_I;
                    address_next = i_address;
                    read_next    = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d_next = 1'b0;
`endif
                end
            end
            SERVE_I: begin
                if (pmem_resp) begin
                    i_resp     = 1'b1;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            SERVE_D: begin
                if (pmem_resp) begin
                    d_resp     = 1'b1;
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    state_next = RELEASE;
                end
            end
            RELEASE: begin
                // One dead cycle so a requester's held request cannot be re-granted.
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
                read_next  = 1'b0;
                write_next = 1'b0;
            end
        endcase
    end

    // State and registered memory-side outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            pmem_read    <= 1'b0;
            pmem_write   <= 1'b0;
            pmem_address <= '0;
            pmem_wdata   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_d       <= 1'b0;
`endif
        end else begin
            state        <= state_next;
            pmem_read    <= read_next;
            pmem_write   <= write_next;
            pmem_address <= address_next;
            pmem_wdata   <= wdata_next;
`ifdef ARB_ROUND_ROBIN_EN
            last_d       <= last_d_next;
`endif
        end
    end

    // Flag a D-cache that requests read and write at once.
    always_ff @(posedge clk) begin
        assert (rst || !(d_read && d_write));
    end

endmodule

// File: tb/tb_cacheline_arbiter.sv
// tb/tb_cacheline_arbiter.sv - directed scoreboard bench for cacheline_arbiter
module tb_cacheline_arbiter;

    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          i_read;
    logic [AW-1:0] i_address;
    logic [LW-1:0] i_rdata;
    logic          i_resp;
    logic          d_read;
    logic          d_write;
    logic [AW-1:0] d_address;
    logic [LW-1:0] d_wdata;
    logic [LW-1:0] d_rdata;
    logic          d_resp;
    logic          pmem_read;
    logic          pmem_write;
    logic [AW-1:0] pmem_address;
    logic [LW-1:0] pmem_wdata;
    logic [LW-1:0] pmem_rdata;
    logic          pmem_resp;

    typedef struct packed {
        logic          is_d;
        logic [LW-1:0] data;
    } exp_t;

    exp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    logic [LW-1:0] junk;
    logic [LW-1:0] line_a5;
    logic [LW-1:0] line_wb;

    cacheline_arbiter #(.LINE_WIDTH(LW), .ADDR_WIDTH(AW)) dut (
        .clk(clk), .rst(rst),
        .i_read(i_read), .i_address(i_address), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_address(d_address), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_address(pmem_address),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] obs, input logic [LW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_resp(input logic is_d, input logic [LW-1:0] data);
        exp_t e;
        e.is_d = is_d;
        e.data = data;
        sb.push_back(e);
    endtask

    // Acts as the memory: waits for the grant, checks the held strobes, responds after lat cycles.
    task automatic serve(input string tag, input int glat, input logic w, input logic [AW-1:0] addr,
                         input logic [LW-1:0] wd, input int lat, input logic [LW-1:0] rd);
        int n = 0;
        while (!(pmem_read || pmem_write) && n < 12) begin
            tick();
            n++;
        end
        chk({tag, "_grant_lat"}, n, glat);
        if (n >= 12) return;
        for (int k = 0; k <= lat; k++) begin
            chk({tag, "_rd"}, pmem_read, !w);
            chk({tag, "_wr"}, pmem_write, w);
            chk({tag, "_addr"}, pmem_address, addr);
            if (w) chk({tag, "_wdata"}, pmem_wdata, wd);
            if (k == lat) begin
                pmem_resp  = 1'b1;
                pmem_rdata = rd;
            end else begin
                tick();
            end
        end
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = junk;
        chk({tag, "_rel_rd"}, pmem_read, 1'b0);
        chk({tag, "_rel_wr"}, pmem_write, 1'b0);
    endtask

    initial begin
        junk      = {8{32'hBAD0_F00D}};
        line_a5   = {32{8'hA5}};
        line_wb   = {8{32'h1234_5678}};
        rst       = 1'b1;
        i_read    = 1'b0;
        i_address = '0;
        d_read    = 1'b0;
        d_write   = 1'b0;
        d_address = '0;
        d_wdata   = '0;
        pmem_rdata = junk;
        pmem_resp = 1'b0;

        fork
            forever begin
                @(negedge clk);
                if (!rst && (i_resp || d_resp)) begin
                    if (sb.size() == 0) begin
                        chk("unexpected_resp", {254'b0, d_resp, i_resp}, '0);
                    end else begin
                        exp_t e;
                        e = sb.pop_front();
                        chk("resp_d", d_resp, e.is_d);
                        chk("resp_i", i_resp, !e.is_d);
                        chk("resp_data", e.is_d ? d_rdata : i_rdata, e.data);
                    end
                end
            end
        join_none

        // Reset values
        repeat (2) tick();
        chk("rst_pmem_read", pmem_read, 1'b0);
        chk("rst_pmem_write", pmem_write, 1'b0);
        chk("rst_i_resp", i_resp, 1'b0);
        chk("rst_d_resp", d_resp, 1'b0);
        chk("rst_pmem_address", pmem_address, '0);
        chk("rst_pmem_wdata", pmem_wdata, '0);
        rst = 1'b0;
        tick();

        // I fill alone, memory answers 3 cycles after the strobe
        i_address = 32'h0000_0060;
        i_read    = 1'b1;
        expect_resp(1'b0, line_a5);
        serve("ifill", 1, 1'b0, 32'h60, '0, 3, line_a5);
        i_read = 1'b0;
        tick();

        // D writeback, latency 5
        d_address = 32'h8000_0040;
        d_wdata   = line_wb;
        d_write   = 1'b1;
        expect_resp(1'b1, {8{32'hCAFE_0001}});
        serve("dwb", 1, 1'b1, 32'h8000_0040, line_wb, 5, {8{32'hCAFE_0001}});
        d_write = 1'b0;
        d_wdata = '0;
        tick();

        // Contention from reset: D first, then D re-requests during RELEASE
        rst = 1'b1;
        tick();
        rst = 1'b0;
        i_address = 32'h0000_0100;
        d_address = 32'h0000_0200;
        i_read    = 1'b1;
        d_read    = 1'b1;
        expect_resp(1'b1, {8{32'h0000_0D01}});
        serve("cont_d", 1, 1'b0, 32'h200, '0, 2, {8{32'h0000_0D01}});
        d_address = 32'h0000_0300;
`ifdef ARB_ROUND_ROBIN_EN
        expect_resp(1'b0, {8{32'h0000_0101}});
        serve("cont_rr_i", 2, 1'b0, 32'h100, '0, 1, {8{32'h0000_0101}});
        i_read = 1'b0;
        expect_resp(1'b1, {8{32'h0000_0D02}});
        serve("cont_rr_d", 2, 1'b0, 32'h300, '0, 1, {8{32'h0000_0D02}});
        d_read = 1'b0;
`else
        expect_resp(1'b1, {8{32'h0000_0D02}});
        serve("cont_fix_d", 2, 1'b0, 32'h300, '0, 1, {8{32'h0000_0D02}});
        d_read = 1'b0;
        expect_resp(1'b0, {8{32'h0000_0101}});
        serve("cont_fix_i", 2, 1'b0, 32'h100, '0, 1, {8{32'h0000_0101}});
        i_read = 1'b0;
`endif
        tick();

        // Held stale request: i_read stays high through RELEASE
        i_address = 32'h0000_0400;
        i_read    = 1'b1;
        expect_resp(1'b0, {8{32'h0000_0401}});
        serve("stale", 1, 1'b0, 32'h400, '0, 2, {8{32'h0000_0401}});
        tick();
        i_read = 1'b0;
        chk("stale_idle_rd", pmem_read, 1'b0);
        tick();
        chk("stale_after_rd", pmem_read, 1'b0);

        // Reset two cycles into SERVE_D, then a late response
        d_address = 32'h0000_0500;
        d_read    = 1'b1;
        tick();
        chk("rstmid_grant_rd", pmem_read, 1'b1);
        tick();
        tick();
        #2;
        rst = 1'b1;
        #1;
        chk("rstmid_async_rd", pmem_read, 1'b0);
        chk("rstmid_async_addr", pmem_address, '0);
        d_read = 1'b0;
        tick();
        rst        = 1'b0;
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h0000_0501}};
        #2;
        chk("rstmid_late_d_resp", d_resp, 1'b0);
        chk("rstmid_late_i_resp", i_resp, 1'b0);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = junk;
        chk("rstmid_idle_rd", pmem_read, 1'b0);
        i_address = 32'h0000_0600;
        i_read    = 1'b1;
        expect_resp(1'b0, {8{32'h0000_0601}});
        serve("post_rst", 1, 1'b0, 32'h600, '0, 1, {8{32'h0000_0601}});
        i_read = 1'b0;
        tick();

        // Spurious pmem_resp in IDLE
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'h0000_0701}};
        #2;
        chk("spur_i_resp", i_resp, 1'b0);
        chk("spur_d_resp", d_resp, 1'b0);
        tick();
        pmem_resp  = 1'b0;
        pmem_rdata = junk;
        chk("spur_rd", pmem_read, 1'b0);
        chk("spur_wr", pmem_write, 1'b0);
        d_address = 32'h0000_0700;
        d_read    = 1'b1;
        expect_resp(1'b1, {8{32'h0000_0702}});
        serve("post_spur", 1, 1'b0, 32'h700, '0, 1, {8{32'h0000_0702}});
        d_read = 1'b0;
        repeat (3) tick();

        chk("sb_empty", sb.size(), '0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
